// File: rtl/msg_serializer_pkg.sv
// Shared types and header packing for the message beat serializer.
package msg_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD
  } state_e;

  localparam int HDR_ID_W  = 16;
  localparam int HDR_LEN_W = 16;
  localparam int HDR_W     = HDR_ID_W + HDR_LEN_W;

  function automatic logic [HDR_W-1:0] pack_header(input logic [HDR_ID_W-1:0]  id,
                                                   input logic [HDR_LEN_W-1:0] len);
    return {id, len};
  endfunction

endpackage

// File: rtl/msg_beat_serializer_if.sv
// Enqueue and beat method signals of the serializer, grouped as one bundle.
interface msg_beat_serializer_if #(
  parameter int width = 32
);
  logic             EN_enq;
  logic             RDY_enq;
  logic [width-1:0] enq_data;
  logic             enq_last;
  logic             EN_beat;
  logic             RDY_beat;
  logic [width-1:0] beat;
  logic             last;
  logic             err_overflow;

  modport master (
    output EN_enq, enq_data, enq_last, EN_beat,
    input  RDY_enq, RDY_beat, beat, last, err_overflow
  );

  modport slave (
    input  EN_enq, enq_data, enq_last, EN_beat,
    output RDY_enq, RDY_beat, beat, last, err_overflow
  );
endinterface

// File: rtl/msg_sync_fifo.sv
// Single-clock FIFO with registered count; head word is visible without a pop.
module msg_sync_fifo #(
  parameter  int W     = 32,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // NOTE: storage is deliberately not reset; count and pointers alone decide which entries are valid.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: clocked state uses <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/msg_beat_serializer.sv
// Store-and-forward serializer: buffers complete messages, then emits a header
// beat (portal id, length) followed by the payload beats.
module msg_beat_serializer
  import msg_serializer_pkg::*;
#(
  parameter int width     = 32,
  parameter int DEPTH     = 16,
  parameter int PORTAL_ID = 0
) (
  input logic                  CLK,
  input logic                  RST,
  msg_beat_serializer_if.slave bus
);
  localparam int DCW       = $clog2(DEPTH + 1);
  localparam int LEN_DEPTH = 2;
  localparam int LCW       = $clog2(LEN_DEPTH + 1);

  state_e               state_q, state_d;
  logic [HDR_LEN_W-1:0] rem_q, rem_d;
  logic [HDR_LEN_W-1:0] wr_cnt_q, wr_cnt_d;
  logic                 err_q, err_d;

  logic                 data_full, data_empty, len_full, len_empty;
  logic [DCW-1:0]       data_count;
  logic [LCW-1:0]       len_count;
  logic [width-1:0]     data_head;
  logic [HDR_LEN_W-1:0] len_head, len_wdata;
  logic                 rdy_enq, enq_fire, at_cap, msg_end;
  logic                 data_pop, len_pop;
  logic                 rdy_beat, beat_last;
  logic [width-1:0]     beat;

  assign rdy_enq   = !data_full && !len_full;
  assign enq_fire  = bus.EN_enq && rdy_enq;
  assign at_cap    = (32'(wr_cnt_q) + 32'd1) == 32'(DEPTH);
  // A full buffer closes the message even without enq_last; later words open a new one.
  assign msg_end   = enq_fire && (bus.enq_last || at_cap);
  assign len_wdata = wr_cnt_q + 16'd1;
  assign err_d     = err_q || (msg_end && !bus.enq_last);

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (enq_fire) wr_cnt_d = msg_end ? '0 : wr_cnt_q + 1'b1;
  end

  msg_sync_fifo #(.W(width), .DEPTH(DEPTH)) u_data_fifo (
    .CLK(CLK), .RST(RST), .push_i(enq_fire), .wdata_i(bus.enq_data), .pop_i(data_pop),
    .rdata_o(data_head), .full_o(data_full), .empty_o(data_empty), .count_o(data_count)
  );

  msg_sync_fifo #(.W(HDR_LEN_W), .DEPTH(LEN_DEPTH)) u_len_fifo (
    .CLK(CLK), .RST(RST), .push_i(msg_end), .wdata_i(len_wdata), .pop_i(len_pop),
    .rdata_o(len_head), .full_o(len_full), .empty_o(len_empty), .count_o(len_count)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    len_pop   = 1'b0;
    data_pop  = 1'b0;
    rdy_beat  = 1'b0;
    beat      = '0;
    beat_last = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!len_empty) state_d = HEADER;
      end
      HEADER: begin
        rdy_beat = 1'b1;
        beat     = width'(pack_header(HDR_ID_W'(PORTAL_ID), len_head));
        if (bus.EN_beat) begin
          rem_d   = len_head;
          len_pop = 1'b1;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        rdy_beat  = 1'b1;
        beat      = data_head;
        beat_last = (rem_q == 16'd1);
        if (bus.EN_beat) begin
          data_pop = 1'b1;
          rem_d    = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      wr_cnt_q <= wr_cnt_d;
      err_q    <= err_d;
    end
  end

  assign bus.RDY_enq      = rdy_enq;
  assign bus.RDY_beat     = rdy_beat;
  assign bus.beat         = beat;
  assign bus.last         = beat_last;
  assign bus.err_overflow = err_q;

  // Payload beats are only offered for words already buffered; headers only for queued lengths.
  a_payload_present: assert property (@(posedge CLK) disable iff (RST)
    (state_q == PAYLOAD) |-> (!data_empty && (32'(data_count) >= 32'(rem_q))));
  a_header_queued: assert property (@(posedge CLK) disable iff (RST)
    (state_q == HEADER) |-> (len_count != '0));

endmodule

// File: tb/tb_msg_beat_serializer.sv
// Directed bench for msg_beat_serializer with width=32, DEPTH=16, PORTAL_ID=5.
module tb_msg_beat_serializer;
  localparam int W   = 32;
  localparam int D   = 16;
  localparam int PID = 5;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 CLK = ~CLK;

  msg_beat_serializer_if #(.width(W)) bus ();

  msg_beat_serializer #(.width(W), .DEPTH(D), .PORTAL_ID(PID)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] hdr(input int len);
    return {16'(PID), 16'(len)};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.EN_enq   = 1'b0;
    bus.enq_data = '0;
    bus.enq_last = 1'b0;
    bus.EN_beat  = 1'b0;
  endtask

  // Presents one word and returns one cycle after it was accepted.
  task automatic enq_word(input logic [31:0] d, input logic l);
    int n = 0;
    while (!bus.RDY_enq && n < 100) begin
      step();
      n++;
    end
    if (!bus.RDY_enq) begin
      vectors++;
      miscompares++;
      $display("FAIL enq_timeout RDY_enq=%b exp=1", bus.RDY_enq);
    end
    bus.EN_enq   = 1'b1;
    bus.enq_data = d;
    bus.enq_last = l;
    step();
    bus.EN_enq   = 1'b0;
    bus.enq_last = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    vectors++;
    if ({bus.RDY_enq, bus.err_overflow} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_enq RDY_enq,err=%b exp=10", {bus.RDY_enq, bus.err_overflow});
    end
    vectors++;
    if ({bus.RDY_beat, bus.last, bus.beat} !== 34'h0) begin
      miscompares++;
      $display("FAIL reset_beat rdy,last,beat=%h exp=0", {bus.RDY_beat, bus.last, bus.beat});
    end
  endtask

  task automatic test_single();
    bus.EN_beat = 1'b1;
    enq_word(32'hA5A5A5A5, 1'b1);
    vectors++;
    if (bus.RDY_beat !== 1'b0) begin
      miscompares++;
      $display("FAIL single_n1 RDY_beat=%b exp=0", bus.RDY_beat);
    end
    step();
    vectors++;
    if ({bus.RDY_beat, bus.last, bus.beat} !== {2'b10, 32'h00050001}) begin
      miscompares++;
      $display("FAIL single_hdr rdy,last,beat=%h exp=%h", {bus.RDY_beat, bus.last, bus.beat}, {2'b10, 32'h00050001});
    end
    step();
    vectors++;
    if ({bus.RDY_beat, bus.last, bus.beat} !== {2'b11, 32'hA5A5A5A5}) begin
      miscompares++;
      $display("FAIL single_data rdy,last,beat=%h exp=%h", {bus.RDY_beat, bus.last, bus.beat}, {2'b11, 32'hA5A5A5A5});
    end
    step();
    vectors++;
    if (bus.RDY_beat !== 1'b0) begin
      miscompares++;
      $display("FAIL single_after RDY_beat=%b exp=0", bus.RDY_beat);
    end
    bus.EN_beat = 1'b0;
  endtask

  task automatic test_stall();
    logic [31:0] words [3];
    words = '{32'h11111111, 32'h22222222, 32'h33333333};
    bus.EN_beat = 1'b0;
    for (int i = 0; i < 3; i++) enq_word(words[i], i == 2);
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) bus.EN_beat = 1'b1;
      vectors++;
      if ({bus.RDY_beat, bus.last, bus.beat} !== {2'b10, hdr(3)}) begin
        miscompares++;
        $display("FAIL stall_hdr cyc=%0d rdy,last,beat=%h exp=%h", i, {bus.RDY_beat, bus.last, bus.beat}, {2'b10, hdr(3)});
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({bus.RDY_beat, bus.last, bus.beat} !== {1'b1, i == 2, words[i]}) begin
        miscompares++;
        $display("FAIL stall_data idx=%0d rdy,last,beat=%h exp=%h", i, {bus.RDY_beat, bus.last, bus.beat}, {1'b1, i == 2, words[i]});
      end
      step();
    end
    vectors++;
    if (bus.RDY_beat !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_after RDY_beat=%b exp=0", bus.RDY_beat);
    end
    bus.EN_beat = 1'b0;
  endtask

  task automatic test_fill();
    bus.EN_beat = 1'b0;
    for (int i = 0; i < D; i++) begin
      enq_word(32'h100 + i, 1'b0);
      if (i == D - 2) begin
        vectors++;
        if ({bus.RDY_enq, bus.err_overflow} !== 2'b10) begin
          miscompares++;
          $display("FAIL fill_pre RDY_enq,err=%b exp=10", {bus.RDY_enq, bus.err_overflow});
        end
      end
    end
    vectors++;
    if ({bus.RDY_enq, bus.err_overflow, bus.RDY_beat} !== 3'b010) begin
      miscompares++;
      $display("FAIL fill_full RDY_enq,err,RDY_beat=%b exp=010", {bus.RDY_enq, bus.err_overflow, bus.RDY_beat});
    end
    step();
    vectors++;
    if ({bus.RDY_enq, bus.RDY_beat, bus.last, bus.beat} !== {3'b010, 32'h00050010}) begin
      miscompares++;
      $display("FAIL fill_hdr rdy_enq,rdy,last,beat=%h exp=%h", {bus.RDY_enq, bus.RDY_beat, bus.last, bus.beat}, {3'b010, 32'h00050010});
    end
    bus.EN_beat = 1'b1;
    step();
    for (int i = 0; i < D; i++) begin
      vectors++;
      if ({bus.RDY_beat, bus.last, bus.beat} !== {1'b1, i == D - 1, 32'h100 + i}) begin
        miscompares++;
        $display("FAIL fill_data idx=%0d rdy,last,beat=%h exp=%h", i, {bus.RDY_beat, bus.last, bus.beat}, {1'b1, i == D - 1, 32'h100 + i});
      end
      step();
    end
    vectors++;
    if ({bus.RDY_beat, bus.RDY_enq, bus.err_overflow} !== 3'b011) begin
      miscompares++;
      $display("FAIL fill_after RDY_beat,RDY_enq,err=%b exp=011", {bus.RDY_beat, bus.RDY_enq, bus.err_overflow});
    end
    bus.EN_beat = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Per cycle: {RDY_enq, RDY_beat, last, beat}
    logic [34:0] tbl [10];
    tbl = '{{3'b010, hdr(2)},         {3'b110, 32'hDEAD0001},
            {3'b011, 32'hDEAD0002},   {3'b000, 32'h0},
            {3'b010, hdr(1)},         {3'b111, 32'hDEAD0003},
            {3'b100, 32'h0},          {3'b110, hdr(1)},
            {3'b111, 32'hC0C0C0C0},   {3'b100, 32'h0}};
    bus.EN_beat = 1'b0;
    enq_word(32'hDEAD0001, 1'b0);
    enq_word(32'hDEAD0002, 1'b1);
    enq_word(32'hDEAD0003, 1'b1);
    bus.EN_beat  = 1'b1;
    bus.enq_data = 32'hC0C0C0C0;
    for (int i = 0; i < 10; i++) begin
      bus.EN_enq   = (i < 2);
      bus.enq_last = (i < 2);
      vectors++;
      if ({bus.RDY_enq, bus.RDY_beat, bus.last, bus.beat} !== tbl[i]) begin
        miscompares++;
        $display("FAIL b2b cyc=%0d rdy_enq,rdy,last,beat=%h exp=%h", i, {bus.RDY_enq, bus.RDY_beat, bus.last, bus.beat}, tbl[i]);
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bus.EN_beat = 1'b0;
    for (int i = 1; i <= 4; i++) enq_word(32'h40000000 + i, i == 4);
    step();
    bus.EN_beat = 1'b1;
    step();
    step();
    step();
    vectors++;
    if ({bus.RDY_beat, bus.last, bus.beat} !== {2'b10, 32'h40000003}) begin
      miscompares++;
      $display("FAIL mid_pre rdy,last,beat=%h exp=%h", {bus.RDY_beat, bus.last, bus.beat}, {2'b10, 32'h40000003});
    end
    RST = 1'b1;
    #1;
    vectors++;
    if ({bus.RDY_enq, bus.err_overflow, bus.RDY_beat, bus.last, bus.beat} !== {4'b1000, 32'h0}) begin
      miscompares++;
      $display("FAIL mid_rst rdy_enq,err,rdy,last,beat=%h exp=%h", {bus.RDY_enq, bus.err_overflow, bus.RDY_beat, bus.last, bus.beat}, {4'b1000, 32'h0});
    end
    step();
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({bus.RDY_enq, bus.err_overflow, bus.RDY_beat, bus.last, bus.beat} !== {4'b1000, 32'h0}) begin
        miscompares++;
        $display("FAIL mid_post cyc=%0d rdy_enq,err,rdy,last,beat=%h exp=%h", i, {bus.RDY_enq, bus.err_overflow, bus.RDY_beat, bus.last, bus.beat}, {4'b1000, 32'h0});
      end
      step();
    end
    enq_word(32'h12345678, 1'b1);
    step();
    vectors++;
    if ({bus.RDY_beat, bus.last, bus.beat} !== {2'b10, hdr(1)}) begin
      miscompares++;
      $display("FAIL mid_fresh_hdr rdy,last,beat=%h exp=%h", {bus.RDY_beat, bus.last, bus.beat}, {2'b10, hdr(1)});
    end
    step();
    vectors++;
    if ({bus.RDY_beat, bus.last, bus.beat} !== {2'b11, 32'h12345678}) begin
      miscompares++;
      $display("FAIL mid_fresh_data rdy,last,beat=%h exp=%h", {bus.RDY_beat, bus.last, bus.beat}, {2'b11, 32'h12345678});
    end
    step();
    vectors++;
    if (bus.RDY_beat !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_fresh_after RDY_beat=%b exp=0", bus.RDY_beat);
    end
    bus.EN_beat = 1'b0;
  endtask

  task automatic test_random_stream();
    logic [31:0] in_data [$];
    logic        in_last [$];
    logic [32:0] exp_q [$];
    int          in_idx  = 0;
    int          out_idx = 0;
    int          cyc     = 0;
    logic        fire;
    for (int m = 0; m < 8; m++) begin
      int len = $urandom_range(1, 4);
      exp_q.push_back({1'b0, hdr(len)});
      for (int k = 0; k < len; k++) begin
        logic [31:0] w = {8'(m), 8'(k), 16'($urandom_range(0, 65535))};
        in_data.push_back(w);
        in_last.push_back(k == len - 1);
        exp_q.push_back({k == len - 1, w});
      end
    end
    while (out_idx < exp_q.size() && cyc < 500) begin
      bus.EN_enq = (in_idx < in_data.size());
      if (bus.EN_enq) begin
        bus.enq_data = in_data[in_idx];
        bus.enq_last = in_last[in_idx];
      end
      bus.EN_beat = ($urandom_range(0, 3) != 0);
      if (bus.RDY_beat && bus.EN_beat) begin
        vectors++;
        if ({bus.last, bus.beat} !== exp_q[out_idx]) begin
          miscompares++;
          $display("FAIL stream idx=%0d last,beat=%h exp=%h", out_idx, {bus.last, bus.beat}, exp_q[out_idx]);
        end
        out_idx++;
      end
      fire = bus.EN_enq && bus.RDY_enq;
      step();
      if (fire) in_idx++;
      cyc++;
    end
    idle_inputs();
    vectors++;
    if (out_idx != exp_q.size()) begin
      miscompares++;
      $display("FAIL stream_count beats=%0d exp=%0d", out_idx, exp_q.size());
    end
    bus.EN_beat = 1'b1;
    step();
    step();
    vectors++;
    if (bus.RDY_beat !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_extra RDY_beat=%b exp=0", bus.RDY_beat);
    end
    bus.EN_beat = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_fill();
    test_back_to_back();
    test_reset_mid();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/msg_beat_serializer.md
# msg_beat_serializer

Store-and-forward stage directly upstream of the simulation message source. Collects one message of payload words from the portal logic, then emits a header beat (portal id, payload length) followed by the payload beats on the `beat` method. `last` marks the final payload beat. The downstream consumer pulls beats with the `EN`/`RDY` method handshake.

## Interface
Parameters:
- `width`, 32: beat and payload word width; must be ≥ 32.
- `DEPTH`, 16: payload-word buffer entries; power of 2, 2..65535; also the maximum message length.
- `PORTAL_ID`, 0: 16-bit id placed in every header.

Ports:
- `CLK`  in  1  clock, single domain.
- `RST`  in  1  reset; asynchronous assert, active-high.
- `EN_enq`  in  1  accept one payload word this cycle; legal only while `RDY_enq`.
- `RDY_enq`  out  1  a payload word can be accepted.
- `enq_data`  in  width  payload word.
- `enq_last`  in  1  word is the final word of its message.
- `EN_beat`  in  1  consumer takes the current beat.
- `RDY_beat`  out  1  `beat`/`last` are valid.
- `beat`  out  width  header or payload beat.
- `last`  out  1  final beat of the message.
- `err_overflow`  out  1  sticky: a message was truncated at `DEPTH` words.

## Operation
- Data FIFO holds `DEPTH` words. Length FIFO holds 2 entries of 16-bit payload counts.
- `RDY_enq` = data FIFO not full && length FIFO not full. Both come from registered state. A dequeue in the same cycle does not free a slot for that cycle.
- Enqueue: `wr_cnt` increments on each accepted word.
  - When `enq_last` is set, push `wr_cnt+1` to the length FIFO and clear `wr_cnt`.
  - If the word that makes `wr_cnt+1 == DEPTH` arrives without `enq_last`, treat it as last (push `DEPTH`) and set `err_overflow`. Later words start a new message.
- Output FSM:
  - IDLE: `RDY_beat`=0. Go to HEADER when the length FIFO is non-empty.
  - HEADER: `RDY_beat`=1, `beat` = {zeros, PORTAL_ID[15:0], len[15:0]}, `last`=0. On `EN_beat`: load `rem`=len, pop the length FIFO, go to PAYLOAD.
  - PAYLOAD: `RDY_beat`=1, `beat` = data FIFO head, `last` = (`rem`==1). On `EN_beat`: pop the data FIFO and decrement `rem`. If `rem`==1, go to IDLE.
- A header is never last, because len ≥ 1.
- The header for message k+1 is not emitted before the last payload beat of message k.
- Simultaneous enqueue and dequeue on the same FIFO are both honoured; the count is unchanged.
- `EN_beat` while `RDY_beat`=0 is ignored. `EN_enq` while `RDY_enq`=0 is ignored; no state changes.

## Timing
- Reset values: FSM IDLE; FIFOs empty; `wr_cnt`=0; `RDY_beat`=0; `beat`=0; `last`=0; `err_overflow`=0. `RDY_enq`=1 in the first cycle after `RST` deasserts.
- `RST` asserted mid-message clears everything. Partial inbound and outbound messages are dropped without a trailing `last`.
- Latency: `enq_last` accepted at cycle N → length entry visible at N+1 → HEADER (`RDY_beat`=1) at N+2.
- With `EN_beat` held high, a message of L words occupies L+1 consecutive beat cycles. One idle cycle (IDLE) follows before the next header.
- `RDY_beat`, `beat` and `last` depend only on registered state, never combinationally on `EN_beat`.
- `RDY_enq` never depends combinationally on `EN_enq` or `EN_beat`.

## Structure
- Package `msg_serializer_pkg`:
  - state enum {IDLE, HEADER, PAYLOAD}
  - `HDR_ID_W`=16, `HDR_LEN_W`=16
  - header-pack function
- Sub-module `msg_sync_fifo` (parameterised width/depth; count, full, empty; async active-high reset). Instantiated twice: payload data, and lengths.

## Test plan
- Single 1-word message 0xA5A5A5A5, `PORTAL_ID`=5, `EN_beat`=1 → header 0x00050001 at N+2, then 0xA5A5A5A5 with `last`=1, then `RDY_beat`=0.
- 3-word message, consumer stalls (`EN_beat`=0) for 4 cycles during the header → header held stable; payload order preserved; `last` only on word 3.
- Fill: 16 words with no `enq_last` (`DEPTH`=16) → 16th accepted as last; `err_overflow`=1; header len=0x0010; `RDY_enq`=0 while full.
- Back-to-back messages of lengths 2 and 1 → beats H(2),w0,w1(last),H(1),w2(last). IDLE gap of exactly 1 cycle. Third message waits while the length FIFO holds 2.
- `RST` pulsed after 2 payload beats of a 4-word message → all outputs return to reset values. A fresh 1-word message then serializes correctly.
- Simultaneous enq and beat dequeue each cycle for 20 cycles with random stalls → scoreboard matches; no loss or duplication.
